// File: rtl/ysyx_23060203_idu_issue_queue.sv
// Decode-front FIFO of fetched {pc, inst} pairs; the head issues only when a per-GPR
// pending-write scoreboard clears its operands. A fence.i at the head waits for an idle scoreboard.
module ysyx_23060203_idu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NWB   = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic [NWB-1:0]           wb_valid,
    input  logic [5*NWB-1:0]         wb_rd,
    output logic                     sb_idle,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_RR     = 5'b01100;
    localparam logic [4:0] OP_FENCEI = 5'b00011;
    localparam logic [4:0] OP_SYS    = 5'b11100;

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    logic [31:0]       underflow;

    logic        empty, enq, issue, hazard;
    logic [4:0]  opcode, rs1, rs2, rd;
    logic        is_fencei, rs1_used, rs2_used, rd_wr;

    assign in_ready  = (occ_q != OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign enq       = in_valid & in_ready & ~flush;
    assign issue     = out_valid & out_ready;
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_inst  = inst_mem[rd_ptr_q];

    assign opcode    = out_inst[6:2];
    assign rd        = out_inst[11:7];
    assign rs1       = out_inst[19:15];
    assign rs2       = out_inst[24:20];
    assign is_fencei = (opcode == OP_FENCEI);
    assign rs1_used  = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                         is_fencei || ((opcode == OP_SYS) && out_inst[14]));
    assign rs2_used  = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_RR);
    assign rd_wr     = !((opcode == OP_BRANCH) || (opcode == OP_STORE)) && (rd != 5'd0);

    always_comb begin
        sb_idle = 1'b1;
        for (int r = 0; r < 32; r++) begin
            if (cnt_q[r] != '0) sb_idle = 1'b0;
        end
    end

    // Counter at max blocks another writer so the increment can never wrap.
    assign hazard = (rs1_used && (rs1 != 5'd0) && (cnt_q[rs1] != '0)) ||
                    (rs2_used && (rs2 != 5'd0) && (cnt_q[rs2] != '0)) ||
                    (rd_wr && (cnt_q[rd] == CNT_MAX)) ||
                    (is_fencei && !sb_idle);

    assign out_valid = ~empty & ~flush & ~hazard;

    always_comb begin : sb_next
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] dec;
        underflow = '0;
        for (int r = 0; r < 32; r++) begin
            sum = SUM_W'(cnt_q[r]);
            if (issue && rd_wr && (rd == 5'(r))) sum = sum + SUM_W'(1);
            dec = '0;
            for (int i = 0; i < NWB; i++) begin
                if (wb_valid[i] && (wb_rd[5*i +: 5] == 5'(r)) && (r != 0)) dec = dec + SUM_W'(1);
            end
            if (dec > sum) begin
                cnt_d[r]     = '0;
                underflow[r] = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - dec);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (enq)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (enq && !issue)      occ_q <= occ_q + OCC_W'(1);
                else if (!enq && issue) occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= in_pc;
            inst_mem[wr_ptr_q] <= in_inst;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && (underflow != '0)) $error("issue_queue: writeback on idle register");
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_idu_issue_queue.sv
// Scoreboard bench for the issue queue: expected {pc, inst} queued at enqueue, compared at issue,
// plus directed RAW, fence.i, flush, saturation and async-reset scenarios.
module tb_ysyx_23060203_idu_issue_queue;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ADDI_X5   = 32'h00100293;
    localparam logic [31:0] ADD_X6    = 32'h00528333;
    localparam logic [31:0] LUI_X7    = 32'h000013B7;
    localparam logic [31:0] SW_X7     = 32'h0070A023;
    localparam logic [31:0] FENCEI    = 32'h0000100F;
    localparam logic [31:0] ADDI_X3   = 32'h00000193;
    localparam logic [31:0] ADDI_X9   = 32'h00000493;

    logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready, sb_idle;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [2:0]  occupancy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;
    entry_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_23060203_idu_issue_queue #(.DEPTH(4), .NWB(2), .CNT_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .sb_idle   (sb_idle),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called just after a negedge with inputs set; books enq/issue, then advances one cycle.
    task automatic step();
        entry_t e;
        #1;
        check("occupancy", 64'(occupancy), 64'(exp_q.size()));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("issue_pc", 64'(out_pc), 64'(e.pc));
                check("issue_inst", 64'(out_inst), 64'(e.inst));
            end
        end
        if (in_valid && in_ready && !flush) begin
            e.pc   = in_pc;
            e.inst = in_inst;
            exp_q.push_back(e);
        end
        if (flush) exp_q.delete();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wb_pulse(input logic [1:0] v, input logic [9:0] rd);
        wb_valid = v;
        wb_rd    = rd;
        step();
        wb_valid = 2'b00;
        wb_rd    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; wb_valid = '0; wb_rd = '0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sb_idle", 64'(sb_idle), 64'(1));
        check("rst_occ", 64'(occupancy), 64'(0));
        reset = 1'b1;
        @(negedge clock);

        // Fill to full with out_ready low, then drain in order.
        for (int i = 0; i < 4; i++) begin
            enq(32'h80000000 + 32'(4 * i), NOP);
            check("fill_head_pc", 64'(out_pc), 64'h80000000);
        end
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_occ", 64'(occupancy), 64'(4));
        check("full_out_valid", 64'(out_valid), 64'(1));
        enq(32'h90000000, NOP);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("drain_done", 64'(occupancy), 64'(0));

        // RAW on x5 released one cycle after its writeback.
        enq(32'h80000100, ADDI_X5);
        enq(32'h80000104, ADD_X6);
        for (int i = 0; i < 3; i++) begin
            check("raw_blocked", 64'(out_valid), 64'(0));
            step();
        end
        wb_valid = 2'b01; wb_rd = 10'd5;
        check("raw_wb_cycle", 64'(out_valid), 64'(0));
        step();
        wb_valid = 2'b00; wb_rd = '0;
        check("raw_unblock", 64'(out_valid), 64'(1));
        step();
        check("sb_busy_x6", 64'(sb_idle), 64'(0));
        wb_pulse(2'b01, 10'd6);
        check("sb_idle_x6", 64'(sb_idle), 64'(1));

        // Issue and writeback of x7 in the same cycle net out.
        out_ready = 1'b0;
        enq(32'h00000200, LUI_X7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        enq(32'h00000204, LUI_X7);
        enq(32'h00000208, SW_X7);
        check("lui_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        wb_pulse(2'b10, {5'd7, 5'd0});
        for (int i = 0; i < 2; i++) begin
            check("sw_blocked", 64'(out_valid), 64'(0));
            check("sb_busy_x7", 64'(sb_idle), 64'(0));
            step();
        end
        wb_pulse(2'b01, 10'd7);
        check("sw_unblock", 64'(out_valid), 64'(1));
        step();
        check("sb_idle_x7", 64'(sb_idle), 64'(1));

        // Two writers of x3 in flight, then flush with three queued entries.
        enq(32'h00000300, ADDI_X3);
        enq(32'h00000304, ADDI_X3);
        step();
        check("x3_pending", 64'(sb_idle), 64'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) enq(32'h00000400 + 32'(4 * i), NOP);
        check("pre_flush_occ", 64'(occupancy), 64'(3));
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h0000040c; in_inst = NOP;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("post_flush_occ", 64'(occupancy), 64'(0));
        check("post_flush_valid", 64'(out_valid), 64'(0));
        check("post_flush_sb", 64'(sb_idle), 64'(0));

        // fence.i drains until both x3 writers retire.
        out_ready = 1'b1;
        enq(32'h00000500, FENCEI);
        for (int i = 0; i < 3; i++) begin
            check("fence_blocked", 64'(out_valid), 64'(0));
            step();
        end
        wb_pulse(2'b01, 10'd3);
        check("fence_one_wb", 64'(out_valid), 64'(0));
        check("fence_sb_busy", 64'(sb_idle), 64'(0));
        wb_pulse(2'b01, 10'd3);
        check("fence_sb_idle", 64'(sb_idle), 64'(1));
        check("fence_unblock", 64'(out_valid), 64'(1));
        step();

        // Saturate x9 at three writers; the fourth waits.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) enq(32'h00000600 + 32'(4 * i), ADDI_X9);
        out_ready = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            check("x9_held", 64'(out_valid), 64'(0));
            step();
        end
        wb_pulse(2'b11, {5'd9, 5'd9});
        check("x9_released", 64'(out_valid), 64'(1));
        step();
        check("x9_pending", 64'(sb_idle), 64'(0));

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        enq(32'h00000700, NOP);
        enq(32'h00000704, NOP);
        in_valid = 1'b1; in_pc = 32'h00000708; in_inst = NOP;
        #3;
        reset = 1'b0;
        #1;
        check("async_occ", 64'(occupancy), 64'(0));
        check("async_sb_idle", 64'(sb_idle), 64'(1));
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        out_ready = 1'b1;
        enq(32'h00000800, NOP);
        step();
        check("final_occ", 64'(occupancy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
